// File: rtl/mult_div_if.sv
// Handshake and result bus between the MIPS datapath and the multiply/divide unit.
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Datapath/control side: issues operations and reads HI/LO.
    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes on start, 32 shift-add or restoring
// shift-subtract steps run in RUN, and FIX applies the sign correction
// and writes HI/LO. Total latency from the start edge is 33 cycles.
module mult_div_unit (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opb;      // mult: multiplicand magnitude; div: divisor magnitude
    logic        r_is_div;
    logic        r_neg_rs;   // set only for signed ops with a negative operand
    logic        r_neg_rt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand conditioning at start: op[1] selects divide, op[0] selects unsigned.
    logic        w_is_div;
    logic        w_neg_rs;
    logic        w_neg_rt;
    logic [31:0] w_mag_rs;
    logic [31:0] w_mag_rt;

    assign w_is_div = bus.op[1];
    assign w_neg_rs = ~bus.op[0] & bus.rs_data[31];
    assign w_neg_rt = ~bus.op[0] & bus.rt_data[31];
    // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign w_mag_rs = w_neg_rs ? -bus.rs_data : bus.rs_data;
    assign w_mag_rt = w_neg_rt ? -bus.rt_data : bus.rt_data;

    // One multiply step: conditionally add the multiplicand to the upper half, shift right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
    assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // One restoring divide step on the 33-bit shifted remainder. When the trial
    // subtract succeeds the difference is below the divisor, so 32 bits hold it.
    logic [32:0] w_rem_sh;
    logic        w_div_ok;
    logic [31:0] w_rem_sub;
    logic [63:0] w_div_step;

    assign w_rem_sh   = r_acc[63:31];
    assign w_div_ok   = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub  = w_rem_sh[31:0] - r_opb;
    assign w_div_step = w_div_ok ? {w_rem_sub, r_acc[30:0], 1'b1}
                                 : {w_rem_sh[31:0], r_acc[30:0], 1'b0};

    // Sign correction and HI/LO values written in FIX.
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    // Select the final HI/LO from the magnitude result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        w_fix_hi = r_acc[63:32];
        w_fix_lo = r_acc[31:0];
        if (!r_is_div) begin
            {w_fix_hi, w_fix_lo} = (r_neg_rs ^ r_neg_rt) ? -r_acc : r_acc;
        end else if (r_opb == 32'd0) begin
            // Divide by zero: quotient all ones; the remainder walked the dividend
            // magnitude through, and restoring its sign gives rs back unchanged.
            w_fix_lo = 32'hFFFF_FFFF;
            w_fix_hi = r_neg_rs ? -r_acc[63:32] : r_acc[63:32];
        end else begin
            w_fix_lo = (r_neg_rs ^ r_neg_rt) ? -r_acc[31:0] : r_acc[31:0];
            w_fix_hi = r_neg_rs ? -r_acc[63:32] : r_acc[63:32];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO writes and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_opb    <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_rs <= 1'b0;
            r_neg_rt <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_div <= w_is_div;
                        r_neg_rs <= w_neg_rs;
                        r_neg_rt <= w_neg_rt;
                        r_opb    <= w_is_div ? w_mag_rt : w_mag_rs;
                        r_acc    <= {32'd0, (w_is_div ? w_mag_rs : w_mag_rt)};
                        r_cnt    <= 6'd0;
                    end else begin
                        if (bus.mthi) r_hi <= bus.rs_data;
                        if (bus.mtlo) r_lo <= bus.rs_data;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (r_state == S_FIX);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random
// vectors against a behavioural model, and hand-written busy/reset sequences.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference using native 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] u;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = 64'(p);
                {hi, lo} = u;
            end
            2'd1: begin
                u = {32'd0, a} * {32'd0, b};
                {hi, lo} = u;
            end
            2'd2: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    u  = 64'(q);
                    lo = u[31:0];
                    u  = 64'(r);
                    hi = u[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Called at the negedge after the start edge with lat0 edges already elapsed.
    task automatic wait_result(input string tag, input int lat0);
        int   lat;
        logic busy_ok;
        exp_t e;
        lat     = lat0;
        busy_ok = 1'b1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'd33);
        check($sformatf("%s busy_held", tag), 32'(busy_ok), 32'd1);
        check($sformatf("%s busy_clear", tag), 32'(bus.busy), 32'd0);
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check($sformatf("%s sb_empty", tag), 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("%s hi", tag), bus.hi, e.hi);
                check($sformatf("%s lo", tag), bus.lo, e.lo);
            end
        end
    endtask

    // Issue one operation starting at the current negedge and check its result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        sb_q.push_back('{hi: exp_hi, lo: exp_lo});
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("%s busy_set", tag), 32'(bus.busy), 32'd1);
        check($sformatf("%s done_low", tag), 32'(bus.done), 32'd0);
        wait_result(tag, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [1:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mh;
        logic [31:0] ml;
        int          n_done;

        vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'd3, 32'h0000_0014, 32'h0000_0000, 32'h0000_0014, 32'hFFFF_FFFF};
        vecs[5]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6]  = '{2'd2, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFEC, 32'hFFFF_FFFF};
        vecs[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[10] = '{2'd0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[11] = '{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back during each done cycle.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
        end

        // Random vectors checked against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = (i % 4 == 3) ? 32'd0 : $urandom;
            if (i % 3 == 1) rb = rb >> $urandom_range(16, 31);
            model(r_op, ra, rb, mh, ml);
            run_op($sformatf("rnd%0d", i), r_op, ra, rb, mh, ml);
        end
        @(negedge clk);
        check("done pulse width", 32'(bus.done), 32'd0);

        // mthi and mtlo together, then individually.
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.rs_data = 32'h3333_3333;
        @(negedge clk);
        check("mt both hi", bus.hi, 32'h3333_3333);
        check("mt both lo", bus.lo, 32'h3333_3333);
        bus.mtlo = 1'b0; bus.rs_data = 32'h1111_1111;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.rs_data = 32'h2222_2222;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mthi hi", bus.hi, 32'h1111_1111);
        check("mtlo lo", bus.lo, 32'h2222_2222);

        // Start MULTU 5*6, then hammer start/mthi/mtlo while busy.
        bus.start = 1'b1; bus.op = 2'd1; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
        sb_q.push_back('{hi: 32'd0, lo: 32'd30});
        @(negedge clk);
        bus.op = 2'd2; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        bus.rs_data = 32'hDEAD_BEEF; bus.rt_data = 32'd0;
        repeat (5) @(negedge clk);
        check("busy ignore hi", bus.hi, 32'h1111_1111);
        check("busy ignore lo", bus.lo, 32'h2222_2222);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        wait_result("busy_ignore", 5);
        @(negedge clk);

        // start wins over mthi/mtlo in the same cycle; then reset at RUN cycle 10.
        bus.start = 1'b1; bus.op = 2'd1; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
        bus.mthi = 1'b1; bus.mtlo = 1'b1;
        sb_q.push_back('{hi: 32'd0, lo: 32'd30});
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("prio hi", bus.hi, 32'd0);
        check("prio lo", bus.lo, 32'd30);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset hi", bus.hi, 32'd0);
        check("async reset lo", bus.lo, 32'd0);
        check("async reset done", 32'(bus.done), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("no done after reset", 32'(n_done), 32'd0);
        run_op("post_reset", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
